prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/prog_clock_divider.sv | 176 +++++++++++++++++
 tb/tb_prog_clock_divider.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Programmable clock divider with a glitch-free run/stop handshake and a
// one-deep pending configuration slot. New divisor/high-count values are
// clamped when accepted and applied only at period boundaries, or straight
// away while idle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | stopped, clock_out low, a pending config is applied at once
// ST_RUN   | dividing, enable high
// ST_DRAIN | enable dropped mid-period, finishing the current period
module prog_clock_divider #(
    parameter int unsigned WIDTH    = 28,
    parameter int unsigned DEF_DIV  = 4,
    parameter int unsigned DEF_HIGH = DEF_DIV / 2
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             clock_out,
    output logic             tick,
    output logic             busy,
    output logic             cfg_adj
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);
    localparam logic [WIDTH-1:0] RST_DIV   = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] RST_HIGH  = WIDTH'(DEF_HIGH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] pdiv_q, pdiv_d;
    logic [WIDTH-1:0] phigh_q, phigh_d;
    logic             pvalid_q, pvalid_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             adj_q, adj_d;

    logic [WIDTH-1:0] acc_div, acc_high, cnt_inc;
    logic             acc_clamped, accept, last;

    // Clamp the offered configuration into a legal (D,H) pair.
    always_comb begin
        acc_div     = cfg_div;
        acc_high    = cfg_high;
        acc_clamped = 1'b0;
        if (cfg_div < TWO) begin
            acc_div     = TWO;
            acc_clamped = 1'b1;
        end
        if (cfg_high == '0) begin
            acc_high    = ONE;
            acc_clamped = 1'b1;
        end
        if (acc_high >= acc_div) begin
            acc_high    = acc_div - ONE;
            acc_clamped = 1'b1;
        end
    end

    assign accept  = cfg_valid && !pvalid_q;
    assign last    = (cnt_q == div_q - ONE);
    assign cnt_inc = cnt_q + ONE;

    // Next-state logic: FSM, period counter, config slots and output strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        high_d   = high_q;
        pdiv_d   = pdiv_q;
        phigh_d  = phigh_q;
        pvalid_d = pvalid_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        adj_d    = accept && acc_clamped;

        // Accept and apply are mutually exclusive: accept needs the slot empty.
        if (accept) begin
            pdiv_d   = acc_div;
            phigh_d  = acc_high;
            pvalid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (pvalid_q) begin
                    div_d    = pdiv_q;
                    high_d   = phigh_q;
                    pvalid_d = 1'b0;
                end
                if (enable) begin
                    state_d = ST_RUN;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (last) begin
                    cnt_d = '0;
                    if (pvalid_q) begin
                        div_d    = pdiv_q;
                        high_d   = phigh_q;
                        pvalid_d = 1'b0;
                    end
                    // Any legal H is at least 1, so a new period always opens high.
                    if (enable) begin
                        state_d = ST_RUN;
                        clk_d   = 1'b1;
                        tick_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        clk_d   = 1'b0;
                    end
                end else begin
                    cnt_d   = cnt_inc;
                    clk_d   = (cnt_inc < high_q);
                    state_d = enable ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    // State registers; reset clears clock_out without waiting for a clock edge.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= RST_DIV;
            high_q   <= RST_HIGH;
            pdiv_q   <= RST_DIV;
            phigh_q  <= RST_HIGH;
            pvalid_q <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            adj_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            high_q   <= high_d;
            pdiv_q   <= pdiv_d;
            phigh_q  <= phigh_d;
            pvalid_q <= pvalid_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            adj_q    <= adj_d;
        end
    end

    assign clock_out = clk_q;
    assign tick      = tick_q;
    assign busy      = (state_q != ST_IDLE);
    assign cfg_ready = !pvalid_q;
    assign cfg_adj   = adj_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: a table of per-cycle stimulus
// and expected outputs, plus hand-written back-to-back config and
// asynchronous-reset sequences.
module tb_prog_clock_divider;

    localparam int W = 28;

    logic         clock_in;
    logic         reset_n;
    logic         enable;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic [W-1:0] cfg_high;
    logic         cfg_ready;
    logic         clock_out;
    logic         tick;
    logic         busy;
    logic         cfg_adj;

    prog_clock_divider #(.WIDTH(W), .DEF_DIV(4), .DEF_HIGH(2)) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_ready (cfg_ready),
        .clock_out (clock_out),
        .tick      (tick),
        .busy      (busy),
        .cfg_adj   (cfg_adj)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        logic         en;
        logic         cv;
        logic [W-1:0] cd;
        logic [W-1:0] ch;
        logic         e_clk;
        logic         e_tick;
        logic         e_busy;
        logic         e_ready;
        logic         e_adj;
    } vec_t;

    typedef struct {
        logic  clk;
        logic  tck;
        logic  bsy;
        logic  rdy;
        logic  adj;
        string tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic row(input logic en, input logic cv, input int cd, input int ch,
                       input logic e_clk, input logic e_tick, input logic e_busy,
                       input logic e_ready, input logic e_adj);
        vec_t v;
        v.en = en; v.cv = cv; v.cd = W'(cd); v.ch = W'(ch);
        v.e_clk = e_clk; v.e_tick = e_tick; v.e_busy = e_busy;
        v.e_ready = e_ready; v.e_adj = e_adj;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue its expectation, then check after the edge.
    task automatic cyc(input vec_t v, input string tag);
        exp_t e;
        enable    = v.en;
        cfg_valid = v.cv;
        cfg_div   = v.cd;
        cfg_high  = v.ch;
        e.clk = v.e_clk; e.tck = v.e_tick; e.bsy = v.e_busy;
        e.rdy = v.e_ready; e.adj = v.e_adj; e.tag = tag;
        sb.push_back(e);
        @(posedge clock_in);
        #2;
        e = sb.pop_front();
        chk({e.tag, ".clock_out"}, clock_out, e.clk);
        chk({e.tag, ".tick"},      tick,      e.tck);
        chk({e.tag, ".busy"},      busy,      e.bsy);
        chk({e.tag, ".cfg_ready"}, cfg_ready, e.rdy);
        chk({e.tag, ".cfg_adj"},   cfg_adj,   e.adj);
    endtask

    task automatic step(input logic en, input logic cv, input int cd, input int ch,
                        input logic e_clk, input logic e_tick, input logic e_busy,
                        input logic e_ready, input logic e_adj, input string tag);
        vec_t v;
        v.en = en; v.cv = cv; v.cd = W'(cd); v.ch = W'(ch);
        v.e_clk = e_clk; v.e_tick = e_tick; v.e_busy = e_busy;
        v.e_ready = e_ready; v.e_adj = e_adj;
        cyc(v, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Defaults 4/2 from idle: 1100 repeating, tick on each rise.
        row(1,0,0,0, 1,1,1,1,0);
        row(1,0,0,0, 1,0,1,1,0);
        row(1,0,0,0, 0,0,1,1,0);
        row(1,0,0,0, 0,0,1,1,0);
        row(1,0,0,0, 1,1,1,1,0);
        row(1,0,0,0, 1,0,1,1,0);
        // Mid-period accept of 5/2: current period stays 1100, then 11000.
        row(1,1,5,2, 0,0,1,0,0);
        row(1,0,0,0, 0,0,1,0,0);
        row(1,0,0,0, 1,1,1,1,0);
        row(1,0,0,0, 1,0,1,1,0);
        row(1,0,0,0, 0,0,1,1,0);
        row(1,0,0,0, 0,0,1,1,0);
        row(1,0,0,0, 0,0,1,1,0);
        row(1,0,0,0, 1,1,1,1,0);
        row(1,0,0,0, 1,0,1,1,0);
        row(1,0,0,0, 0,0,1,1,0);
        row(1,0,0,0, 0,0,1,1,0);
        row(1,0,0,0, 0,0,1,1,0);
        // Enable dropped on the last cycle of a period: straight to idle.
        row(0,0,0,0, 0,0,0,1,0);
        row(0,0,0,0, 0,0,0,1,0);
        // Clamp 1/0 -> 2/1 in idle; adj pulses once, then divide-by-2.
        row(0,1,1,0, 0,0,0,0,1);
        row(0,0,0,0, 0,0,0,1,0);
        row(1,0,0,0, 1,1,1,1,0);
        row(1,0,0,0, 0,0,1,1,0);
        row(1,0,0,0, 1,1,1,1,0);
        row(1,0,0,0, 0,0,1,1,0);
        // 6/3 accepted on a boundary edge: applies at the following boundary.
        row(1,1,6,3, 1,1,1,0,0);
        row(1,0,0,0, 0,0,1,0,0);
        row(1,0,0,0, 1,1,1,1,0);
        row(1,0,0,0, 1,0,1,1,0);
        // Drop enable at counter 1: drain completes 111000, then idle.
        row(0,0,0,0, 1,0,1,1,0);
        row(0,0,0,0, 0,0,1,1,0);
        row(0,0,0,0, 0,0,1,1,0);
        row(0,0,0,0, 0,0,1,1,0);
        row(0,0,0,0, 0,0,0,1,0);
        row(0,0,0,0, 0,0,0,1,0);
        // Restart, drop, re-enable at counter 4: no gap in the waveform.
        row(1,0,0,0, 1,1,1,1,0);
        row(0,0,0,0, 1,0,1,1,0);
        row(0,0,0,0, 1,0,1,1,0);
        row(0,0,0,0, 0,0,1,1,0);
        row(0,0,0,0, 0,0,1,1,0);
        row(1,0,0,0, 0,0,1,1,0);
        row(1,0,0,0, 1,1,1,1,0);
        row(1,0,0,0, 1,0,1,1,0);

        reset_n   = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_high  = '0;
        repeat (3) @(posedge clock_in);
        #2;
        chk("reset.clock_out", clock_out, 1'b0);
        chk("reset.tick",      tick,      1'b0);
        chk("reset.busy",      busy,      1'b0);
        chk("reset.cfg_ready", cfg_ready, 1'b1);
        chk("reset.cfg_adj",   cfg_adj,   1'b0);
        @(negedge clock_in);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i], $sformatf("tbl%0d", i));

        // Back-to-back configs at 6/3 from counter 1: 3/1 then 4/3.
        step(1,1,3,1, 1,0,1,0,0, "b2b0");
        step(1,1,4,3, 0,0,1,0,0, "b2b1");
        step(1,1,4,3, 0,0,1,0,0, "b2b2");
        step(1,1,4,3, 0,0,1,0,0, "b2b3");
        step(1,1,4,3, 1,1,1,1,0, "b2b4");
        step(1,1,4,3, 0,0,1,0,0, "b2b5");
        step(1,0,0,0, 0,0,1,0,0, "b2b6");
        step(1,0,0,0, 1,1,1,1,0, "b2b7");
        step(1,0,0,0, 1,0,1,1,0, "b2b8");
        step(1,0,0,0, 1,0,1,1,0, "b2b9");
        step(1,0,0,0, 0,0,1,1,0, "b2b10");
        step(1,0,0,0, 1,1,1,1,0, "b2b11");

        // Reset in the high phase with a 7/3 pending: clock_out drops at once.
        step(1,1,7,3, 1,0,1,0,0, "arst_pre");
        cfg_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst.clock_out", clock_out, 1'b0);
        chk("arst.busy",      busy,      1'b0);
        chk("arst.cfg_ready", cfg_ready, 1'b1);
        chk("arst.tick",      tick,      1'b0);
        @(negedge clock_in);
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(1,0,0,0, 1,1,1,1,0, $sformatf("post%0d_0", k));
            step(1,0,0,0, 1,0,1,1,0, $sformatf("post%0d_1", k));
            step(1,0,0,0, 0,0,1,1,0, $sformatf("post%0d_2", k));
            step(1,0,0,0, 0,0,1,1,0, $sformatf("post%0d_3", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
